scroll_step_scheduler: RTL and testbench

Sequences the VGA viewport scroll offsets from the four push-buttons. Debounces the buttons, picks one direction by fixed priority, and emits auto-repeat scroll steps with hold-to-accelerate. Steps commit only on frame boundaries, so the offsets never change mid-frame. Its `x_offset`/`y_offset` feed the coordinate-remap stage ahead of the Game-of-Life cell lookup.

---
 rtl/scroll_pkg.sv | 38 +++
 rtl/scroll_step_scheduler_if.sv | 32 +++
 rtl/scroll_step_scheduler_debouncer.sv | 44 ++++
 rtl/scroll_step_scheduler.sv | 166 ++++++++++++++++
 tb/tb_scroll_step_scheduler.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scroll_pkg.sv
// Shared types and display geometry for the viewport scroll scheduler
// and the VGA timing generator.
package scroll_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        RIGHT = 2'b00,
        UP    = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } scroll_dir_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_DELAY  = 3'd2,
        S_REPEAT = 3'd3,
        S_FAST   = 3'd4
    } sched_state_t;

    // Fixed priority over {U, D, L, R}; right is also the fallback when nothing is held.
    function automatic scroll_dir_t pick_dir(input logic [3:0] levels);
        scroll_dir_t dir;
        if (levels[3]) begin
            dir = UP;
        end else if (levels[2]) begin
            dir = DOWN;
        end else if (levels[1]) begin
            dir = LEFT;
        end else begin
            dir = RIGHT;
        end
        return dir;
    endfunction

endpackage

// File: rtl/scroll_step_scheduler_if.sv
// Button/frame inputs and scroll offset outputs of the scroll scheduler.
interface scroll_step_scheduler_if #(
    parameter int XW = $clog2(scroll_pkg::H_ACTIVE),
    parameter int YW = $clog2(scroll_pkg::V_ACTIVE)
) ();

    logic [3:0]    buttons;
    logic          frame_start;
    logic [XW-1:0] x_offset;
    logic [YW-1:0] y_offset;
    logic          step_valid;
    logic [1:0]    active_dir;

    modport master (
        output buttons,
        output frame_start,
        input  x_offset,
        input  y_offset,
        input  step_valid,
        input  active_dir
    );

    modport slave (
        input  buttons,
        input  frame_start,
        output x_offset,
        output y_offset,
        output step_valid,
        output active_dir
    );

endinterface

// File: rtl/scroll_step_scheduler_debouncer.sv
// One push-button: two-flop synchronizer followed by a stability counter that
// accepts a level change only after it persists for DEBOUNCE_CYCLES cycles.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then count consecutive disagreeing cycles before flipping.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign level = level_r;

endmodule

// File: rtl/scroll_step_scheduler.sv
// Turns debounced push-buttons into frame-aligned viewport scroll steps with
// auto-repeat and hold-to-accelerate.
module scroll_step_scheduler #(
    parameter int H_ACTIVE             = scroll_pkg::H_ACTIVE,
    parameter int V_ACTIVE             = scroll_pkg::V_ACTIVE,
    parameter int DEBOUNCE_CYCLES      = 1_000_000,
    parameter int INITIAL_DELAY_FRAMES = 30,
    parameter int REPEAT_FRAMES        = 8,
    parameter int FAST_AFTER_STEPS     = 16,
    parameter int FAST_REPEAT_FRAMES   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    scroll_step_scheduler_if.slave  bus
);

    import scroll_pkg::*;

    localparam int XW   = $clog2(H_ACTIVE);
    localparam int YW   = $clog2(V_ACTIVE);
    localparam int FM1  = (INITIAL_DELAY_FRAMES > REPEAT_FRAMES) ? INITIAL_DELAY_FRAMES : REPEAT_FRAMES;
    localparam int FMAX = (FM1 > FAST_REPEAT_FRAMES) ? FM1 : FAST_REPEAT_FRAMES;
    localparam int FCW  = $clog2(FMAX + 1);
    localparam int SCW  = $clog2(FAST_AFTER_STEPS + 1);

    logic [3:0]    level_s;
    logic          held_s;
    scroll_dir_t   winner_s;

    sched_state_t  state_r, state_n;
    scroll_dir_t   dir_r, dir_n;
    logic [FCW-1:0] frame_cnt_r, frame_cnt_n;
    logic [SCW-1:0] step_cnt_r, step_cnt_n, step_cnt_inc_s;
    logic          step_s;

    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic          step_valid_r;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (bus.buttons[i]),
            .level(level_s[i])
        );
    end

    assign held_s   = |level_s;
    assign winner_s = pick_dir(level_s);

    // Scheduler state, latched direction and frame/step counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            dir_r       <= RIGHT;
            frame_cnt_r <= '0;
            step_cnt_r  <= '0;
        end else begin
            state_r     <= state_n;
            dir_r       <= dir_n;
            frame_cnt_r <= frame_cnt_n;
            step_cnt_r  <= step_cnt_n;
        end
    end

    // Release and re-arming take precedence over any step due on this frame.
    always_comb begin
        state_n        = state_r;
        dir_n          = dir_r;
        frame_cnt_n    = frame_cnt_r;
        step_cnt_n     = step_cnt_r;
        step_s         = 1'b0;
        step_cnt_inc_s = step_cnt_r + SCW'(1);
        if (state_r == S_IDLE) begin
            if (held_s) begin
                state_n     = S_ARMED;
                dir_n       = winner_s;
                frame_cnt_n = '0;
                step_cnt_n  = '0;
            end else begin
                state_n = S_IDLE;
            end
        end else if (!held_s) begin
            state_n = S_IDLE;
        end else if (winner_s != dir_r) begin
            state_n     = S_ARMED;
            dir_n       = winner_s;
            frame_cnt_n = '0;
            step_cnt_n  = '0;
        end else if (bus.frame_start) begin
            case (state_r)
                S_ARMED: begin
                    step_s      = 1'b1;
                    frame_cnt_n = FCW'(INITIAL_DELAY_FRAMES);
                    state_n     = S_DELAY;
                end
                S_DELAY: begin
                    if (frame_cnt_r <= FCW'(1)) begin
                        step_s      = 1'b1;
                        frame_cnt_n = FCW'(REPEAT_FRAMES);
                        step_cnt_n  = '0;
                        state_n     = S_REPEAT;
                    end else begin
                        frame_cnt_n = frame_cnt_r - FCW'(1);
                    end
                end
                S_REPEAT: begin
                    if (frame_cnt_r <= FCW'(1)) begin
                        step_s     = 1'b1;
                        step_cnt_n = step_cnt_inc_s;
                        if (step_cnt_inc_s == SCW'(FAST_AFTER_STEPS)) begin
                            frame_cnt_n = FCW'(FAST_REPEAT_FRAMES);
                            state_n     = S_FAST;
                        end else begin
                            frame_cnt_n = FCW'(REPEAT_FRAMES);
                        end
                    end else begin
                        frame_cnt_n = frame_cnt_r - FCW'(1);
                    end
                end
                S_FAST: begin
                    if (frame_cnt_r <= FCW'(1)) begin
                        step_s      = 1'b1;
                        frame_cnt_n = FCW'(FAST_REPEAT_FRAMES);
                    end else begin
                        frame_cnt_n = frame_cnt_r - FCW'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Offset registers: one axis moves per step, wrapping without a modulo.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r          <= '0;
            y_r          <= '0;
            step_valid_r <= 1'b0;
        end else begin
            step_valid_r <= step_s;
            if (step_s) begin
                case (dir_r)
                    RIGHT:   x_r <= (x_r == XW'(H_ACTIVE - 1)) ? XW'(0) : x_r + XW'(1);
                    LEFT:    x_r <= (x_r == XW'(0)) ? XW'(H_ACTIVE - 1) : x_r - XW'(1);
                    DOWN:    y_r <= (y_r == YW'(V_ACTIVE - 1)) ? YW'(0) : y_r + YW'(1);
                    UP:      y_r <= (y_r == YW'(0)) ? YW'(V_ACTIVE - 1) : y_r - YW'(1);
                    default: x_r <= x_r;
                endcase
            end
        end
    end

    assign bus.x_offset   = x_r;
    assign bus.y_offset   = y_r;
    assign bus.step_valid = step_valid_r;
    assign bus.active_dir = dir_r;

endmodule

// File: tb/tb_scroll_step_scheduler.sv
// Frame-level scoreboard bench for scroll_step_scheduler: directed scenarios
// followed by randomized button patterns, glitches and mid-frame resets.
module tb_scroll_step_scheduler;

    localparam int DEB        = 4;
    localparam int INIT       = 3;
    localparam int REP        = 2;
    localparam int FAST_AFTER = 2;
    localparam int FAST_REP   = 1;
    localparam int FRAME_CYC  = 20;
    localparam int HA         = 640;
    localparam int VA         = 480;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scroll_step_scheduler_if bus ();

    scroll_step_scheduler #(
        .H_ACTIVE            (HA),
        .V_ACTIVE            (VA),
        .DEBOUNCE_CYCLES     (DEB),
        .INITIAL_DELAY_FRAMES(INIT),
        .REPEAT_FRAMES       (REP),
        .FAST_AFTER_STEPS    (FAST_AFTER),
        .FAST_REPEAT_FRAMES  (FAST_REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t       step_q[$];
    int         errors = 0;
    int         checks = 0;
    bit         done   = 1'b0;

    // behavioural model state
    int         mx, my;
    bit         run;
    logic [1:0] run_dir, last_dir;
    int         nsteps, frames_left;
    logic [3:0] cur_pat;
    bit         pend;
    exp_t       pend_e;
    exp_t       exp_frame;

    function automatic logic [1:0] winner_of(input logic [3:0] p);
        if (p[3])      return 2'b01;
        else if (p[2]) return 2'b10;
        else if (p[1]) return 2'b11;
        else           return 2'b00;
    endfunction

    // frames to wait after the n-th step of a hold
    function automatic int interval(input int n);
        if (n == 1)                  return INIT;
        else if (n <= 1 + FAST_AFTER) return REP;
        else                         return FAST_REP;
    endfunction

    task automatic model_step(input logic [1:0] d);
        case (d)
            2'b00:   mx = (mx + 1) % HA;
            2'b11:   mx = (mx + HA - 1) % HA;
            2'b10:   my = (my + 1) % VA;
            default: my = (my + VA - 1) % VA;
        endcase
        pend   = 1'b1;
        pend_e = '{x: mx[9:0], y: my[8:0], d: d};
    endtask

    task automatic model_reset();
        mx = 0; my = 0; run = 1'b0; last_dir = 2'b00;
    endtask

    task automatic model_frame();
        logic [1:0] w;
        w = winner_of(cur_pat);
        exp_frame = '{x: mx[9:0], y: my[8:0], d: (cur_pat == 4'b0000) ? last_dir : w};
        if (cur_pat == 4'b0000) begin
            run = 1'b0;
        end else if (!run || w != run_dir) begin
            run = 1'b1; run_dir = w; last_dir = w;
            nsteps = 1; frames_left = interval(1);
            model_step(w);
        end else begin
            frames_left--;
            if (frames_left == 0) begin
                nsteps++;
                frames_left = interval(nsteps);
                model_step(w);
            end
        end
    endtask

    // One 20-cycle frame: pulse frame_start, then apply the pattern for the next frame.
    task automatic do_frame(input logic [3:0] next_pat, input logic [3:0] gmask, input bit rst_mid);
        @(posedge clk); #1;
        bus.frame_start = 1'b1;
        model_frame();
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        bus.buttons = next_pat;
        cur_pat = next_pat;
        if (pend) step_q.push_back(pend_e);
        pend = 1'b0;
        for (int c = 2; c < FRAME_CYC; c++) begin
            @(posedge clk); #1;
            if (rst_mid && c == 3) rst = 1'b1;
            if (rst_mid && c == 5) begin
                rst = 1'b0;
                model_reset();
            end
            if (gmask != 4'b0000 && c == 10) bus.buttons = next_pat ^ gmask;
            if (gmask != 4'b0000 && c == 13) bus.buttons = next_pat;
        end
    endtask

    // Monitor: every comparison happens here, away from the active edge.
    initial begin : monitor
        bit   prev_fs;
        bit   prev_rst;
        exp_t got, e;
        prev_fs = 1'b0;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            got = '{x: bus.x_offset, y: bus.y_offset, d: bus.active_dir};
            if (prev_rst) begin
                checks++;
                if (got != 21'd0 || bus.step_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: x=%0d y=%0d dir=%0d sv=%0b, required 0/0/0/0",
                             got.x, got.y, got.d, bus.step_valid);
                end
            end else begin
                if (bus.step_valid) begin
                    checks++;
                    if (!prev_fs) begin
                        errors++;
                        $display("FAIL step_timing: step_valid without frame_start in previous cycle at %0t", $time);
                    end
                    checks++;
                    if (step_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_step: x=%0d y=%0d dir=%0d, required no step", got.x, got.y, got.d);
                    end else begin
                        e = step_q.pop_front();
                        if (got != e) begin
                            errors++;
                            $display("FAIL step_value: x=%0d y=%0d dir=%0d, required x=%0d y=%0d dir=%0d",
                                     got.x, got.y, got.d, e.x, e.y, e.d);
                        end
                    end
                end
                if (bus.frame_start) begin
                    checks++;
                    if (got != exp_frame || step_q.size() != 0) begin
                        errors++;
                        $display("FAIL frame_state: x=%0d y=%0d dir=%0d pending=%0d, required x=%0d y=%0d dir=%0d pending=0",
                                 got.x, got.y, got.d, step_q.size(), exp_frame.x, exp_frame.y, exp_frame.d);
                    end
                end
            end
            if (done) begin
                checks++;
                if (step_q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_steps: %0d expected steps never seen, required 0", step_q.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            prev_fs = bus.frame_start;
            prev_rst = rst;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [3:0] p, g;
        int         len;
        bit         r;
        bus.buttons = 4'b0000;
        bus.frame_start = 1'b0;
        cur_pat = 4'b0000;
        pend = 1'b0;
        exp_frame = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // idle
        for (int i = 0; i < 10; i++) do_frame(4'b0000, 4'b0000, 1'b0);
        // tap right
        do_frame(4'b0001, 4'b0000, 1'b0);
        do_frame(4'b0000, 4'b0000, 1'b0);
        do_frame(4'b0000, 4'b0000, 1'b0);
        // hold left across the wrap into fast repeat, then release
        for (int i = 0; i < 12; i++) do_frame(4'b0010, 4'b0000, 1'b0);
        do_frame(4'b0000, 4'b0000, 1'b0);
        do_frame(4'b0000, 4'b0000, 1'b0);
        // short btnD glitches must be rejected
        for (int i = 0; i < 5; i++) do_frame(4'b0000, 4'b0100, 1'b0);
        // U+R, then down wrapping from 479, then switch to right
        do_frame(4'b1001, 4'b0000, 1'b0);
        do_frame(4'b1001, 4'b0000, 1'b0);
        do_frame(4'b0100, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) do_frame(4'b0100, 4'b0000, 1'b0);
        do_frame(4'b0001, 4'b0000, 1'b0);
        do_frame(4'b0001, 4'b0000, 1'b0);
        do_frame(4'b0000, 4'b0000, 1'b0);
        do_frame(4'b0000, 4'b0000, 1'b0);
        // reset while holding left in fast repeat
        for (int i = 0; i < 10; i++) do_frame(4'b0010, 4'b0000, 1'b0);
        do_frame(4'b0010, 4'b0000, 1'b1);
        do_frame(4'b0010, 4'b0000, 1'b0);
        do_frame(4'b0010, 4'b0000, 1'b0);
        do_frame(4'b0000, 4'b0000, 1'b0);
        do_frame(4'b0000, 4'b0000, 1'b0);

        // randomized holds, glitches and occasional resets
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 3) == 0) p = 4'b0000;
            else p = 4'($urandom_range(1, 15));
            len = $urandom_range(1, 10);
            for (int f = 0; f < len; f++) begin
                if ($urandom_range(0, 3) == 0) g = 4'b0001 << $urandom_range(0, 3);
                else g = 4'b0000;
                r = ($urandom_range(0, 29) == 0) && (g == 4'b0000);
                do_frame(p, g, r);
            end
        end
        do_frame(4'b0000, 4'b0000, 1'b0);
        do_frame(4'b0000, 4'b0000, 1'b0);
        done = 1'b1;
    end

endmodule
